// File: rtl/stream_fifo_buffer_pkg.sv
// rtl/stream_fifo_buffer_pkg.sv - shared cache types for the stream prefetch buffer
package stream_fifo_buffer_pkg;

    typedef logic [31:0] phys_t;
    typedef logic [7:0]  uint8_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ARREADY,
        RECEIVING,
        FLUSH_WAIT_ARREADY,
        FLUSH_RECEIVING
    } sb_fifo_state_t;

    localparam int AXI_ID_WIDTH   = 4;
    localparam int AXI_DATA_WIDTH = 32;

endpackage

// File: rtl/axi3_rd_if.sv
// rtl/axi3_rd_if.sv - AXI3 read address and read data channels
interface axi3_rd_if;
    import stream_fifo_buffer_pkg::*;

    logic [AXI_ID_WIDTH-1:0]   arid;
    phys_t                     araddr;
    logic [3:0]                arlen;
    logic [2:0]                arsize;
    logic [1:0]                arburst;
    logic                      arvalid;
    logic                      arready;
    logic [AXI_ID_WIDTH-1:0]   rid;
    logic [AXI_DATA_WIDTH-1:0] rdata;
    logic [1:0]                rresp;
    logic                      rlast;
    logic                      rvalid;
    logic                      rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );

endinterface

// File: rtl/sb_line_fifo.sv
// rtl/sb_line_fifo.sv - in-order line store; beats are written straight into the tail slot
module sb_line_fifo #(
    parameter int LABEL_WIDTH = 27,
    parameter int LINE_WIDTH  = 256,
    parameter int DEPTH       = 4,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int WORD_W     = $clog2(LINE_WIDTH / 32)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   wr_en,
    input  logic [WORD_W-1:0]      wr_word,
    input  logic [31:0]            wr_data,
    input  logic                   push,
    input  logic [LABEL_WIDTH-1:0] push_label,
    input  logic                   pop,
    output logic [LABEL_WIDTH-1:0] head_label,
    output logic [LINE_WIDTH-1:0]  head_data,
    output logic [PTR_W:0]         count,
    output logic                   full,
    output logic                   empty
);

    logic [LABEL_WIDTH-1:0] label_mem [DEPTH];
    logic [LINE_WIDTH-1:0]  data_mem  [DEPTH];
    logic [PTR_W-1:0]       head;
    logic [PTR_W-1:0]       tail;
    logic                   do_push;
    logic                   do_pop;

    assign full       = (count == (PTR_W+1)'(DEPTH));
    assign empty      = (count == '0);
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign head_label = label_mem[head];
    assign head_data  = data_mem[head];

    // clr outranks push/pop so a restart never keeps a line from the old stream
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + 1'b1;
            if (do_pop)  head <= head + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)   data_mem[tail][32*int'(wr_word) +: 32] <= wr_data;
        if (do_push) label_mem[tail] <= push_label;
    end

endmodule

// File: rtl/stream_fifo_buffer.sv
// rtl/stream_fifo_buffer.sv - sequential line prefetcher feeding a cache through an in-order FIFO
module stream_fifo_buffer
    import stream_fifo_buffer_pkg::*;
#(
    parameter int LINE_WIDTH        = 256,
    parameter int DEPTH             = 4,
    parameter int ARID              = 2,
    localparam int LINE_BYTE_OFFSET = $clog2(LINE_WIDTH / 8),
    localparam int LABEL_WIDTH      = $bits(phys_t) - LINE_BYTE_OFFSET,
    localparam int WORD_W           = $clog2(LINE_WIDTH / 32),
    localparam int CNT_W            = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LABEL_WIDTH-1:0] start_label,
    input  logic                   start,
    input  logic                   inv,
    input  logic [LABEL_WIDTH-1:0] lookup_label,
    input  logic                   lookup_vld,
    output logic                   hit,
    output logic [LINE_WIDTH-1:0]  hit_data,
    axi3_rd_if.master              axi3_rd_if,
    output logic                   active
);

    sb_fifo_state_t         state;
    sb_fifo_state_t         state_nx;
    logic [LABEL_WIDTH-1:0] next_label;
    logic [LABEL_WIDTH-1:0] ar_label;
    logic [WORD_W-1:0]      beat;
    logic [LABEL_WIDTH-1:0] head_label;
    logic [CNT_W-1:0]       count;
    logic                   full;
    logic                   empty;
    logic                   flush_req;
    logic                   issue;
    logic                   r_fire;
    logic                   r_done;
    logic                   unused_rsp;

    assign flush_req  = inv || start;
    assign r_fire     = axi3_rd_if.rvalid && axi3_rd_if.rready;
    assign r_done     = r_fire && axi3_rd_if.rlast;
    // only IDLE issues, so nothing is in flight and count alone bounds occupancy
    assign issue      = (state == IDLE) && active && (count < CNT_W'(DEPTH)) && !flush_req;
    assign hit        = lookup_vld && !empty && (head_label == lookup_label);
    assign unused_rsp = ^{axi3_rd_if.rid, axi3_rd_if.rresp};

    assign axi3_rd_if.arid    = AXI_ID_WIDTH'(ARID);
    assign axi3_rd_if.araddr  = {ar_label, {LINE_BYTE_OFFSET{1'b0}}};
    assign axi3_rd_if.arlen   = 4'(LINE_WIDTH / 32 - 1);
    assign axi3_rd_if.arsize  = 3'b010;
    assign axi3_rd_if.arburst = 2'b01;
    assign axi3_rd_if.arvalid = (state == WAIT_ARREADY) || (state == FLUSH_WAIT_ARREADY);
    assign axi3_rd_if.rready  = (state == RECEIVING) || (state == FLUSH_RECEIVING);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:               if (issue) state_nx = WAIT_ARREADY;
            WAIT_ARREADY: begin
                if (flush_req)
                    state_nx = axi3_rd_if.arready ? FLUSH_RECEIVING : FLUSH_WAIT_ARREADY;
                else if (axi3_rd_if.arready)
                    state_nx = RECEIVING;
            end
            RECEIVING: begin
                if (r_done)         state_nx = IDLE;
                else if (flush_req) state_nx = FLUSH_RECEIVING;
            end
            FLUSH_WAIT_ARREADY: if (axi3_rd_if.arready) state_nx = FLUSH_RECEIVING;
            FLUSH_RECEIVING:    if (r_done) state_nx = IDLE;
            default:            state_nx = IDLE;
        endcase
    end

    // ar_label freezes the burst address so a restart cannot disturb a pending AR
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            active     <= 1'b0;
            next_label <= '0;
            ar_label   <= '0;
            beat       <= '0;
        end else begin
            state <= state_nx;
            if (inv) begin
                active <= 1'b0;
            end else if (start) begin
                active     <= 1'b1;
                next_label <= start_label;
            end else if (issue) begin
                next_label <= next_label + 1'b1;
            end
            if (issue)  ar_label <= next_label;
            if (r_fire) beat <= axi3_rd_if.rlast ? '0 : beat + 1'b1;
        end
    end

    sb_line_fifo #(
        .LABEL_WIDTH (LABEL_WIDTH),
        .LINE_WIDTH  (LINE_WIDTH),
        .DEPTH       (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clr        (flush_req),
        .wr_en      ((state == RECEIVING) && r_fire),
        .wr_word    (beat),
        .wr_data    (axi3_rd_if.rdata),
        .push       ((state == RECEIVING) && r_done && !full),
        .push_label (ar_label),
        .pop        (hit),
        .head_label (head_label),
        .head_data  (hit_data),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

endmodule

// File: tb/tb_stream_fifo_buffer.sv
// tb/tb_stream_fifo_buffer.sv - bench for stream_fifo_buffer with an AXI3 read slave model
module tb_stream_fifo_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic [26:0]  start_label;
    logic         start;
    logic         inv;
    logic [26:0]  lookup_label;
    logic         lookup_vld;
    logic         hit;
    logic [255:0] hit_data;
    logic         active;

    int tests_run    = 0;
    int tests_failed = 0;

    axi3_rd_if bus ();

    stream_fifo_buffer #(.LINE_WIDTH(256), .DEPTH(4), .ARID(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_label  (start_label),
        .start        (start),
        .inv          (inv),
        .lookup_label (lookup_label),
        .lookup_vld   (lookup_vld),
        .hit          (hit),
        .hit_data     (hit_data),
        .axi3_rd_if   (bus),
        .active       (active)
    );

    always #5 clk = ~clk;

    logic [31:0] salt;
    logic [31:0] ar_log [$];
    logic        stall;
    logic        busy;
    int          sbeat;
    logic [26:0] cur_label;
    logic [3:0]  cap_arlen;
    logic [2:0]  cap_arsize;
    logic [1:0]  cap_arburst;
    logic [3:0]  cap_arid;

    function automatic logic [31:0] word_of(input logic [26:0] lbl, input int k);
        return ({5'd0, lbl} * 32'h9E3779B1) ^ (32'(k) * 32'h85EBCA6B) ^ salt;
    endfunction

    function automatic logic [255:0] line_of(input logic [26:0] lbl);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = word_of(lbl, k);
        return l;
    endfunction

    // Slave: memory contents are word_of(label, beat); sampled on posedge, driven 1 ns later
    initial begin
        logic        ar_fire;
        logic        r_fire;
        logic [31:0] addr_s;
        busy = 1'b0; sbeat = 0; stall = 1'b0; cur_label = '0;
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rlast = 1'b0;
        bus.rdata = '0; bus.rid = '0; bus.rresp = '0;
        forever begin
            @(posedge clk);
            ar_fire = bus.arvalid && bus.arready;
            r_fire  = bus.rvalid && bus.rready;
            addr_s  = bus.araddr;
            if (ar_fire) begin
                cap_arlen = bus.arlen; cap_arsize = bus.arsize;
                cap_arburst = bus.arburst; cap_arid = bus.arid;
            end
            #1;
            if (rst) begin
                busy = 1'b0; sbeat = 0;
                bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rlast = 1'b0;
            end else begin
                if (ar_fire) begin
                    ar_log.push_back(addr_s);
                    cur_label = addr_s[31:5];
                    busy = 1'b1; sbeat = 0;
                end else if (r_fire) begin
                    if (sbeat == 7) busy = 1'b0;
                    else sbeat++;
                end
                bus.arready = !busy && (!stall || $urandom_range(0, 2) == 0);
                bus.rvalid  = busy && (!stall || $urandom_range(0, 2) != 0);
                bus.rlast   = busy && (sbeat == 7);
                bus.rdata   = busy ? word_of(cur_label, sbeat) : 32'd0;
                bus.rid     = 4'd2;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic wait_count(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dut.u_fifo.count == 3'(n)) begin ok = 1'b1; break; end
        end
    endtask

    task automatic pulse_start(input logic [26:0] l);
        start_label = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; lookup_vld = 1'b1; lookup_label = '0;
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if (hit !== 1'b0) begin tests_failed++; $display("FAIL reset_hit: got %b want 0", hit); end
        tests_run++;
        if (bus.arvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_arvalid: got %b want 0", bus.arvalid); end
        tests_run++;
        if (bus.rready !== 1'b0) begin tests_failed++; $display("FAIL reset_rready: got %b want 0", bus.rready); end
        tests_run++;
        if (active !== 1'b0) begin tests_failed++; $display("FAIL reset_active: got %b want 0", active); end
        tests_run++;
        if (dut.u_fifo.count !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", dut.u_fifo.count); end
        @(negedge clk);
        rst = 1'b0; lookup_vld = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fill();
        bit ok;
        bit saw_ar = 1'b0;
        ar_log.delete();
        pulse_start(27'h100);
        wait_count(4, 300, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL fill_timeout: count %0d want 4", dut.u_fifo.count); end
        repeat (20) begin @(negedge clk); if (bus.arvalid) saw_ar = 1'b1; end
        tests_run++;
        if (ar_log.size() != 4 || saw_ar) begin
            tests_failed++; $display("FAIL fill_ar_count: got %0d ars (late arvalid %b) want 4", ar_log.size(), saw_ar);
        end
        for (int i = 0; i < 4; i++) begin
            logic [31:0] got;
            got = (i < ar_log.size()) ? ar_log[i] : 32'hDEADBEEF;
            tests_run++;
            if (got !== 32'h2000 + 32'(32 * i)) begin
                tests_failed++; $display("FAIL fill_araddr%0d: got %h want %h", i, got, 32'h2000 + 32'(32 * i));
            end
        end
        tests_run++;
        if ({cap_arlen, cap_arsize, cap_arburst, cap_arid} !== {4'd7, 3'b010, 2'b01, 4'd2}) begin
            tests_failed++;
            $display("FAIL fill_ar_attrs: got len %0d size %0d burst %0d id %0d want 7 2 1 2",
                     cap_arlen, cap_arsize, cap_arburst, cap_arid);
        end
        tests_run++;
        if (active !== 1'b1) begin tests_failed++; $display("FAIL fill_active: got %b want 1", active); end
    endtask

    task automatic test_hit_refill();
        bit ok = 1'b0;
        lookup_label = 27'h100; lookup_vld = 1'b1;
        #1;
        tests_run++;
        if (hit !== 1'b1) begin tests_failed++; $display("FAIL hit_flag: got %b want 1", hit); end
        tests_run++;
        if (hit_data !== line_of(27'h100)) begin tests_failed++; $display("FAIL hit_data: got %h want %h", hit_data, line_of(27'h100)); end
        @(negedge clk);
        lookup_vld = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (ar_log.size() >= 5) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        tests_run++;
        if (!ok || ar_log[4] !== 32'h2080) begin
            tests_failed++; $display("FAIL refill_araddr: got %0d ars, last %h want 32'h2080", ar_log.size(), ar_log[ar_log.size()-1]);
        end
        wait_count(4, 100, ok);
    endtask

    task automatic test_miss();
        lookup_label = 27'h105; lookup_vld = 1'b1;
        #1;
        tests_run++;
        if (hit !== 1'b0) begin tests_failed++; $display("FAIL miss_hit: got %b want 0", hit); end
        @(negedge clk);
        lookup_label = 27'h101; lookup_vld = 1'b0;
        #1;
        tests_run++;
        if (dut.u_fifo.count !== 3'd4) begin tests_failed++; $display("FAIL miss_count: got %0d want 4", dut.u_fifo.count); end
        tests_run++;
        if (hit !== 1'b0 || hit_data !== line_of(27'h101)) begin
            tests_failed++; $display("FAIL miss_head: hit %b data %h want 0 %h", hit, hit_data, line_of(27'h101));
        end
    endtask

    task automatic test_inv_burst();
        bit found = 1'b0;
        bit dropped = 1'b0;
        bit saw_ar = 1'b0;
        ar_log.delete();
        lookup_label = 27'h101; lookup_vld = 1'b1;
        @(negedge clk);
        lookup_vld = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.rvalid && sbeat == 3) begin found = 1'b1; break; end
        end
        inv = 1'b1;
        @(negedge clk);
        inv = 1'b0;
        for (int i = 0; i < 30 && busy; i++) begin
            if (!bus.rready) dropped = 1'b1;
            @(negedge clk);
        end
        tests_run++;
        if (!found || dropped || busy) begin
            tests_failed++; $display("FAIL inv_drain: beat3 seen %b rready dropped %b still busy %b want 1 0 0", found, dropped, busy);
        end
        repeat (30) begin @(negedge clk); if (bus.arvalid) saw_ar = 1'b1; end
        tests_run++;
        if (dut.u_fifo.count !== 3'd0 || active !== 1'b0) begin
            tests_failed++; $display("FAIL inv_clear: count %0d active %b want 0 0", dut.u_fifo.count, active);
        end
        tests_run++;
        if (saw_ar || ar_log.size() != 1 || ar_log[0] !== 32'h20A0) begin
            tests_failed++; $display("FAIL inv_no_ar: %0d ars first %h late arvalid %b want 1 20a0 0", ar_log.size(), ar_log[0], saw_ar);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        ar_log.delete();
        pulse_start(27'h7FFFFFF);
        wait_count(4, 300, ok);
        tests_run++;
        if (!ok || ar_log[0] !== 32'hFFFFFFE0 || ar_log[1] !== 32'h0 || ar_log[2] !== 32'h20) begin
            tests_failed++; $display("FAIL wrap_addr: got %h %h %h want ffffffe0 0 20", ar_log[0], ar_log[1], ar_log[2]);
        end
        lookup_label = 27'h7FFFFFF; lookup_vld = 1'b1;
        #1;
        tests_run++;
        if (hit !== 1'b1 || hit_data !== line_of(27'h7FFFFFF)) begin
            tests_failed++; $display("FAIL wrap_hit_top: hit %b data %h want 1 %h", hit, hit_data, line_of(27'h7FFFFFF));
        end
        @(negedge clk);
        lookup_label = 27'h0;
        #1;
        tests_run++;
        if (hit !== 1'b1 || hit_data !== line_of(27'h0)) begin
            tests_failed++; $display("FAIL wrap_hit_zero: hit %b data %h want 1 %h", hit, hit_data, line_of(27'h0));
        end
        @(negedge clk);
        lookup_vld = 1'b0;
    endtask

    task automatic test_push_pop();
        bit ok;
        bit found = 1'b0;
        pulse_start(27'h200);
        wait_count(2, 300, ok);
        for (int i = 0; i < 40; i++) begin
            if (bus.rvalid && bus.rlast) begin found = 1'b1; break; end
            @(negedge clk);
        end
        tests_run++;
        if (!ok || !found || dut.u_fifo.count !== 3'd2) begin
            tests_failed++; $display("FAIL pp_setup: count %0d rlast seen %b want 2 1", dut.u_fifo.count, found);
        end
        lookup_label = 27'h200; lookup_vld = 1'b1;
        #1;
        tests_run++;
        if (hit !== 1'b1) begin tests_failed++; $display("FAIL pp_hit: got %b want 1", hit); end
        @(negedge clk);
        lookup_vld = 1'b0;
        #1;
        tests_run++;
        if (dut.u_fifo.count !== 3'd2) begin tests_failed++; $display("FAIL pp_count: got %0d want 2", dut.u_fifo.count); end
        for (int i = 1; i <= 2; i++) begin
            lookup_label = 27'h200 + 27'(i); lookup_vld = 1'b1;
            #1;
            tests_run++;
            if (hit !== 1'b1 || hit_data !== line_of(27'h200 + 27'(i))) begin
                tests_failed++; $display("FAIL pp_order%0d: hit %b data %h want 1 %h", i, hit, hit_data, line_of(27'h200 + 27'(i)));
            end
            @(negedge clk);
        end
        lookup_vld = 1'b0;
    endtask

    // Model: the stream is consecutive labels from the last start; only the next one may hit
    task automatic test_random();
        logic [26:0] exp_head;
        bit          m_active = 1'b1;
        int          pops = 0;
        stall = 1'b1;
        exp_head = 27'($urandom);
        pulse_start(exp_head);
        for (int c = 0; c < 1500; c++) begin
            int r;
            bit other;
            bit do_inv;
            bit do_start;
            r = $urandom_range(0, 99);
            do_inv = (r < 1);
            do_start = (r >= 1 && r < 3);
            inv = do_inv; start = do_start;
            start_label = 27'($urandom);
            lookup_vld = 1'($urandom_range(0, 1));
            other = ($urandom_range(0, 3) == 0);
            lookup_label = other ? exp_head + 27'($urandom_range(1, 6)) : exp_head;
            #1;
            if (!lookup_vld || other || !m_active) begin
                tests_run++;
                if (hit !== 1'b0) begin
                    tests_failed++; $display("FAIL rand_spurious_hit: cycle %0d label %h head %h got %b want 0", c, lookup_label, exp_head, hit);
                end
            end else if (hit) begin
                tests_run++;
                if (hit_data !== line_of(exp_head)) begin
                    tests_failed++; $display("FAIL rand_hit_data: cycle %0d label %h got %h want %h", c, exp_head, hit_data, line_of(exp_head));
                end
                pops++;
                exp_head = exp_head + 27'd1;
            end
            if (do_inv) m_active = 1'b0;
            else if (do_start) begin m_active = 1'b1; exp_head = start_label; end
            @(negedge clk);
        end
        inv = 1'b0; start = 1'b0; lookup_vld = 1'b0;
        tests_run++;
        if (pops < 10) begin tests_failed++; $display("FAIL rand_progress: got %0d pops want >= 10", pops); end
    endtask

    initial begin
        salt = $urandom;
        start = 1'b0; inv = 1'b0; start_label = '0;
        lookup_vld = 1'b0; lookup_label = '0; rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_fill();
        test_hit_refill();
        test_miss();
        test_inv_burst();
        test_wrap();
        test_push_pop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/stream_fifo_buffer.md
STREAM_FIFO_BUFFER -- requirements
Module: stream_fifo_buffer

Interface
REQ-001 SHALL have parameter LINE_WIDTH, 256, cache line width in bits (multiple of 32).
REQ-002 SHALL have parameter DEPTH, 4, number of prefetched line entries (power of two, >=2).
REQ-003 SHALL have parameter ARID, 2, AXI read ID driven on every request.
REQ-004 SHALL derive LINE_BYTE_OFFSET = clog2(LINE_WIDTH/8) and LABEL_WIDTH = width(phys_t) - LINE_BYTE_OFFSET.
REQ-005 SHALL have ports: clk  input  1  clock, the only clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 start_label  input  LABEL_WIDTH  first line label of a new stream.
REQ-008 start  input  1  begin (or restart) a stream at start_label.
REQ-009 inv  input  1  kill stream, discard all entries.
REQ-010 lookup_label  input  LABEL_WIDTH  label requested by cache.
REQ-011 lookup_vld  input  1  lookup_label valid this cycle.
REQ-012 hit  output  1  head entry valid and matches lookup_label.
REQ-013 hit_data  output  LINE_WIDTH  head entry line data.
REQ-014 axi3_rd_if  axi3_rd_if.master  --  AXI3 read channel.
REQ-015 active  output  1  stream running (prefetch enabled).

Function
REQ-016 Entries SHALL form an in-order FIFO of {label, data}; count 0..DEPTH; head/tail pointers wrap modulo DEPTH.
REQ-017 hit SHALL be combinational: lookup_vld & count!=0 & head label == lookup_label; hit_data SHALL equal head data regardless of hit.
REQ-018 On hit the head SHALL pop at the clock edge; a non-matching lookup SHALL NOT change state.
REQ-019 Fetch counter next_label SHALL increment by 1 per issued burst, wrapping modulo 2^LABEL_WIDTH.
REQ-020 At most one burst outstanding; a burst SHALL be issued only when active & count + in-flight < DEPTH.
REQ-021 AR request: araddr = {next_label, LINE_BYTE_OFFSET zeros}, arlen = LINE_WIDTH/32-1, arsize 3'b010, arburst INCR, arid ARID; arvalid held until arready.
REQ-022 States: IDLE, WAIT_ARREADY, RECEIVING, FLUSH_WAIT_ARREADY, FLUSH_RECEIVING.
REQ-023 IDLE -> WAIT_ARREADY when issue condition of REQ-020 holds; WAIT_ARREADY -> RECEIVING on arready; RECEIVING -> IDLE on rvalid & rlast.
REQ-024 rready SHALL be 1 in RECEIVING and FLUSH_RECEIVING; beat k SHALL be written to word k of the tail line buffer.
REQ-025 On rlast in RECEIVING the line SHALL push at tail; push and pop in the same cycle SHALL leave count unchanged.
REQ-026 inv or start while in WAIT_ARREADY SHALL go to FLUSH_WAIT_ARREADY; in RECEIVING to FLUSH_RECEIVING; flush states complete the burst and discard data, then IDLE.
REQ-027 inv SHALL clear all entries and active next cycle; start SHALL clear entries, set active=1 and next_label=start_label next cycle; inv has priority over start.
REQ-028 A hit on the cycle of inv or start SHALL still report hit combinationally; the pop is superseded by the clear.
REQ-029 No new AR SHALL issue from a flush state or before the flush burst completes.

Reset
REQ-030 On rst: state IDLE, count 0, pointers 0, beat counter 0, active 0, next_label 0, arvalid 0, rready 0, hit 0; line data not reset.
REQ-031 rst mid-burst SHALL abandon the burst without draining (AXI slave shares rst).

Structure
REQ-032 sb_fifo_state_t enum SHALL live in the shared cache package with phys_t and uint8_t.
REQ-033 Entry storage SHALL be a sub-module sb_line_fifo (DEPTH x {label, data}, push/pop/count, full/empty).

Verification (LINE_WIDTH 256, DEPTH 4)
REQ-034 start label 0x100 -> AR addrs 0x2000, 0x2020, 0x2040, 0x2060 in order, then no AR while count=4.
REQ-035 Full FIFO, lookup 0x100 -> hit=1 same cycle, hit_data = first line, AR 0x2080 issued next.
REQ-036 lookup 0x105 with head 0x101 -> hit=0, count unchanged.
REQ-037 inv during beat 3 of a burst -> rready held to rlast, no push, count=0, no AR afterwards.
REQ-038 start label 0x7FFFFFF -> next AR label wraps to 0x0000000.
REQ-039 Push and hit in same cycle with count=2 -> count stays 2, FIFO order preserved.
